// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// Holds the per-request operation encoding and the scheduler FSM states.
package mul_div_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply / restoring-divide datapath, one bit per cycle.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         load operands/op and initialise the accumulator
//   calc_i          perform one step this cycle
//   op_i, a_i, b_i  operation and operands sampled on start_i
//   done_o          strobe: the step taken this cycle is the last one
//   res_o           accumulator value after this cycle's step
//                   (multiply: product, divide: {remainder, quotient})
module mul_div_iter
    import mul_div_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic           calc_i,
    input  logic           op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] res_o
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(W);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            op_q, op_d;

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
        shifted = acc_q[2*W-1:W-1];
        diff    = shifted - {1'b0, b_q};

        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            op_d  = op_i;
            cnt_d = '0;
            acc_d = (op_i == OP_MUL) ? {{W{1'b0}}, b_i} : {{W{1'b0}}, a_i};
        end else if (calc_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntW'(1);
            if (op_q == OP_MUL) begin
                acc_d = {sum, acc_q[W-1:1]};
            end else if (!diff[W]) begin
                acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_d = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end
    end

    assign done_o = calc_i && (cnt_q == LastCnt);
    assign res_o  = acc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_MUL;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
        end
    end

endmodule

// File: rtl/mul_div_sched.sv
// Two-requester round-robin scheduler around a shared iterative mul/div unit.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (at most one ready bit high)
//   req_op, req_a, req_b   per-requester op (0 mul, 1 div) and W-bit operand slices
//   rsp_valid/rsp_ready    result handshake
//   rsp_id, rsp_result     owning requester and result (product or {rem, quot})
//   rsp_dbz                divide-by-zero flag
module mul_div_sched
    import mul_div_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req_op,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_result,
    output logic           rsp_dbz
);

    state_e         state_q, state_d;
    logic           rr_last_q, rr_last_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [2*W-1:0] rsp_result_q, rsp_result_d;
    logic           rsp_dbz_q, rsp_dbz_d;

    logic           grant_id;
    logic           accept;
    logic           sel_op;
    logic [W-1:0]   sel_a, sel_b;
    logic           iter_start, iter_calc, iter_done;
    logic [2*W-1:0] iter_res;

    // On a tie the requester not served last wins; otherwise the lone valid one.
    assign grant_id  = (&req_valid) ? ~rr_last_q : ~req_valid[0];
    assign req_ready = (rst_n && (state_q == StIdle) && (|req_valid)) ?
                       (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel_op    = grant_id ? req_op[1] : req_op[0];
    assign sel_a     = grant_id ? req_a[2*W-1:W] : req_a[W-1:0];
    assign sel_b     = grant_id ? req_b[2*W-1:W] : req_b[W-1:0];

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_dbz_d    = rsp_dbz_q;
        iter_start   = 1'b0;
        iter_calc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rsp_id_d = grant_id;
                    if ((sel_op == OP_DIV) && (sel_b == '0)) begin
                        // Divide by zero bypasses the datapath entirely.
                        state_d      = StDone;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = {sel_a, {W{1'b1}}};
                        rsp_dbz_d    = 1'b1;
                    end else begin
                        state_d    = StCalc;
                        iter_start = 1'b1;
                        rsp_dbz_d  = 1'b0;
                    end
                end
            end
            StCalc: begin
                iter_calc = 1'b1;
                if (iter_done) begin
                    state_d      = StDone;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = iter_res;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rr_last_d   = rsp_id_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_last_q    <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_dbz_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_dbz_q    <= rsp_dbz_d;
        end
    end

    mul_div_iter #(
        .W(W)
    ) u_iter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(iter_start),
        .calc_i (iter_calc),
        .op_i   (sel_op),
        .a_i    (sel_a),
        .b_i    (sel_b),
        .done_o (iter_done),
        .res_o  (iter_res)
    );

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_dbz    = rsp_dbz_q;

endmodule

// File: doc/mul_div_sched.md
MUL_DIV_SCHED -- requirements
Module: mul_div_sched

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 SHALL have port req_op  input  2  bit i: 0 = multiply, 1 = divide, for requester i.
REQ-007 SHALL have port req_a  input  2*W  dividend/multiplicand; slice [i*W +: W] = requester i.
REQ-008 SHALL have port req_b  input  2*W  divisor/multiplier; slice [i*W +: W] = requester i.
REQ-009 SHALL have port rsp_valid  output  1  result valid.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  output  1  requester index that owns the result.
REQ-012 SHALL have port rsp_result  output  2*W  multiply: full product; divide: {remainder, quotient}.
REQ-013 SHALL have port rsp_dbz  output  1  divide-by-zero flag for the current result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-015 In IDLE, req_ready SHALL be high combinationally for the granted requester only; a request is accepted on the edge where req_valid[i] and req_ready[i] are both high.
REQ-016 Arbitration SHALL be round-robin. With both requesters valid, grant goes to the requester other than rr_last. With one valid, that requester is granted.
REQ-017 rr_last SHALL update to the served requester when its response handshake completes.
REQ-018 On accept, operands, op and id SHALL be captured. Request inputs are ignored outside IDLE, and req_ready is 0 outside IDLE.
REQ-019 Multiply SHALL be unsigned shift-add, one bit per cycle.
REQ-020 Divide SHALL be unsigned restoring division, one bit per cycle.
REQ-021 A normal op SHALL go IDLE->CALC on accept and run exactly W CALC steps. rsp_valid SHALL rise W edges after the accept edge.
REQ-022 A divide with b==0 SHALL go IDLE->DONE on the accept edge, so rsp_valid rises 1 edge after accept. Result: quotient all-ones, remainder = a, rsp_dbz=1.
REQ-023 rsp_dbz SHALL be 0 for every multiply and for every divide with b!=0.
REQ-024 In DONE, rsp_valid, rsp_id, rsp_result and rsp_dbz SHALL stay stable until rsp_ready is high. The FSM then returns to IDLE on that edge.
REQ-025 No new request SHALL be accepted in the same cycle as the response handshake. The earliest next accept is the following cycle.
REQ-026 Operand 0 cases SHALL produce a correct result via the normal path: a=0 gives product 0 or quotient 0; b=0 on multiply gives product 0.
REQ-027 The iteration counter SHALL be ceil(log2(W+1)) bits and SHALL NOT wrap during CALC.

Reset
REQ-028 On rst_n low, state SHALL be IDLE immediately.
REQ-029 On rst_n low, rr_last SHALL be 1, so requester 0 wins the first tie.
REQ-030 On rst_n low, rsp_valid, rsp_id, rsp_result, rsp_dbz, the counter and all operand registers SHALL be 0.
REQ-031 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation. No response SHALL be produced for it after reset release.
REQ-032 req_ready SHALL be 0 while rst_n is low.

Structure
REQ-033 A shared package mul_div_pkg SHALL hold the op encoding (OP_MUL=0, OP_DIV=1) and the FSM state enum.
REQ-034 The iterative datapath SHALL be one sub-module, mul_div_iter, containing the accumulator/shift registers, the step logic and the done strobe.
REQ-035 Arbitration, FSM and handshakes SHALL reside in mul_div_sched.

Verification (W=8)
REQ-036 Requester 0 multiplies a=24, b=2 -> rsp_result=48, rsp_id=0, rsp_dbz=0, rsp_valid 8 edges after accept.
REQ-037 Requester 1 multiplies 255 x 255 -> rsp_result=16'hFE01.
REQ-038 Divides 200/7 and 24/2 -> rsp_result={8'd4,8'd28} and {8'd0,8'd12}.
REQ-039 Divide 5/0 -> rsp_result={8'd5,8'hFF}, rsp_dbz=1, rsp_valid 1 edge after accept.
REQ-040 Both req_valid held high for 4 ops -> grants in order 0,1,0,1; never two req_ready bits high at once.
REQ-041 rsp_ready held low 3 cycles in DONE -> outputs stable and no new accept.
REQ-042 rst_n pulsed low mid-CALC -> outputs reset immediately and no stale rsp_valid after release.
